nibble_add_sequencer: RTL
=========================

# nibble_add_sequencer

Multi-cycle controller that time-shares a single 4-bit adder slice to add two NIBBLES×4-bit operands nibble by nibble, LSB first, with a registered ripple carry. It sits between the board switch/key front end and the LEDR/HEX display. It captures an operand pair on a start request, sequences the slice for NIBBLES cycles, then presents the registered sum, carry-out and active-low hex-digit segment patterns.

## Interface
- NIBBLES, 4: operand width in nibbles (W = 4·NIBBLES); legal range 1..8.
- CLOCK_50  in  1  system clock; all state updates on its rising edge.
- RESET_N  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- op_a  in  W  operand A.
- op_b  in  W  operand B.
- cin  in  1  carry into nibble 0.
- busy  out  1  high while an addition is in progress.
- done  out  1  one-cycle pulse when result/cout update.
- result  out  W  registered sum, low W bits.
- cout  out  1  registered carry out of the top nibble.
- valid  out  1  high once any addition has completed since reset.
- HEX  out  7·NIBBLES  segments, active-low, {g,f,e,d,c,b,a} per digit; digit i shows result[4i+3:4i].

## Operation
- States: IDLE, ADD.
- IDLE + start=1: capture op_a, op_b, cin into internal registers; idx←0; carry←cin; busy←1; go to ADD. IDLE + start=0: hold.
- ADD, each edge: slice computes {c, s} = a_reg[idx] + b_reg[idx] + carry (5-bit result); shadow[idx]←s; carry←c; idx←idx+1.
- ADD with idx=NIBBLES-1: additionally result←completed shadow, cout←c, done←1, valid←1, busy←0; go to IDLE.
- done is 0 on every other edge.
- start while busy=1 is ignored; it is not queued. Operand changes during ADD have no effect.
- start=1 in the cycle done=1 is accepted (state is IDLE).
- result, cout and HEX hold their values between operations and change only on the done edge.
- HEX: all digits 7'h7F (blank) while valid=0; otherwise the hex glyph 0–F of each result nibble.
- Arithmetic is modular: result = (op_a + op_b + cin) mod 2^W; cout = bit W.

## Timing
- Reset (asynchronous, immediate): state IDLE, busy 0, done 0, result 0, cout 0, valid 0, idx 0, carry 0, HEX all 7'h7F.
- RESET_N asserted mid-operation aborts the operation. No done pulse follows release.
- Latency: start sampled at edge E0. busy is high for exactly NIBBLES cycles (E0..E_NIBBLES). done, result and cout are valid after edge E_NIBBLES.
- Throughput: one operation per NIBBLES+1 cycles with start held high.
- HEX is combinational from result and valid; there is no extra latency.

## Structure
- Shared package `nibble_add_pkg`:
  - state enum {IDLE, ADD}.
  - SEG_BLANK = 7'h7F.
  - 16-entry active-low glyph constant: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- One sub-module `nibble_adder_slice`: combinational 4-bit a, b, ci → 4-bit s, co. It is instantiated once and is the only adder in the block.
- The glyph lookup is a package function, replicated per digit.

## Test plan
All scenarios use NIBBLES=4.
- Reset: RESET_N low → busy 0, done 0, result 16'h0000, cout 0, valid 0, HEX = 28'hFFFFFFF.
- op_a=16'h1234, op_b=16'h4321, cin=0, start pulsed one cycle → busy high 4 cycles; done pulses once; result 16'h5555, cout 0; each digit 7'b0010010.
- op_a=16'hFFFF, op_b=16'h0000, cin=1 → result 16'h0000, cout 1; each digit 7'b1000000 (carry ripples through all 4 nibbles).
- op_a=16'h8000, op_b=16'h800A, cin=1 → result 16'h000B, cout 1; digit0 7'b0000011, digits 3..1 7'b1000000.
- start held high, operands changed every cycle → operands captured only on accepting edges; done every 5 cycles; each result matches the operands sampled at its accept edge.
- RESET_N low for one cycle at the 2nd ADD edge of an operation → outputs cleared immediately; no done after release; the next start completes correctly.

Source files
------------

// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial adder: FSM states and
// active-low seven-segment glyphs ({g,f,e,d,c,b,a}) for the hex display.
package nibble_add_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Element [n] is the glyph for hex digit n.
    localparam logic [15:0][6:0] GLYPH = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        return GLYPH[nib];
    endfunction

endpackage

// File: rtl/nibble_adder_slice.sv
// Combinational 4-bit adder slice with carry in/out; the only adder in the
// sequencer, reused once per nibble.
module nibble_adder_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] sum;

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
        {co, s} = sum;
    end

endmodule

// File: rtl/nibble_add_sequencer.sv
// Time-shares one 4-bit adder slice to add two NIBBLES-wide operands LSB
// nibble first, then presents the registered sum, carry-out and hex digits.
module nibble_add_sequencer
    import nibble_add_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   CLOCK_50,
    input  logic                   RESET_N,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   valid,
    output logic [7*NIBBLES-1:0]   HEX
);

    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      carry_q, carry_d;
    logic [NIBBLES-1:0][3:0]   a_q, a_d;
    logic [NIBBLES-1:0][3:0]   b_q, b_d;
    logic [NIBBLES-1:0][3:0]   shadow_q, shadow_d;
    logic [NIBBLES-1:0][3:0]   result_q, result_d;
    logic                      cout_q, cout_d;
    logic                      done_q, done_d;
    logic                      valid_q, valid_d;

    logic [3:0] slice_s;
    logic       slice_co;

    nibble_adder_slice u_slice (
        .a  (a_q[idx_q]),
        .b  (b_q[idx_q]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        shadow_d = shadow_q;
        result_d = result_q;
        cout_d   = cout_q;
        done_d   = 1'b0;
        valid_d  = valid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                shadow_d[idx_q] = slice_s;
                carry_d         = slice_co;
                idx_d           = idx_q + 1'b1;
                // Result takes the shadow including the nibble produced this cycle.
                if (idx_q == LAST_IDX) begin
                    result_d = shadow_d;
                    cout_d   = slice_co;
                    done_d   = 1'b1;
                    valid_d  = 1'b1;
                    idx_d    = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            shadow_q <= shadow_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        HEX = '1;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            HEX[7*i +: 7] = valid_q ? hex_glyph(result_q[i]) : SEG_BLANK;
        end
    end

    assign busy   = (state_q == ADD);
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign valid  = valid_q;

endmodule
